// File: rtl/flop_en_pipe.sv
// flop_en_pipe: elastic enabled register pipeline with valid/ready and bubble collapsing.
// Defining FLOP_PIPE_OCC_EN adds the occ port and its occupancy counter.
module flop_en_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q
`ifdef FLOP_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);
    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH:0]   adv, vs;
    logic [WIDTH-1:0] r_q [DEPTH];
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [WIDTH-1:0] rs  [DEPTH+1];
    // vs/rs index i is the source feeding stage i; index DEPTH is the output stage itself
    always_comb begin
        adv[DEPTH] = out_ready;
        for (int i = DEPTH-1; i >= 0; i--) adv[i] = ~v_q[i] | adv[i+1];
        vs = {v_q, in_valid};
        rs[0] = d;
        for (int i = 0; i < DEPTH; i++) rs[i+1] = r_q[i];
        for (int i = 0; i < DEPTH; i++) begin
            v_d[i] = flush ? 1'b0 : (en & adv[i]) ? vs[i] : v_q[i];
            r_d[i] = (en & adv[i] & vs[i] & ~flush) ? rs[i] : r_q[i];
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) r_q[i] <= rst ? RST_VAL : r_d[i];
        v_q <= rst ? '0 : v_d;
    end
    assign in_ready  = en & adv[0];
    assign out_valid = en & vs[DEPTH];
    assign q         = rs[DEPTH];
`ifdef FLOP_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH+1);
    logic [OW-1:0] occ_q, occ_d;
    always_comb occ_d = flush ? '0 : occ_q + OW'(in_ready & in_valid) - OW'(out_valid & out_ready);
    always_ff @(posedge clk) occ_q <= rst ? '0 : occ_d;
    assign occ = occ_q;
`endif
endmodule

// File: tb/tb_flop_en_pipe.sv
// tb_flop_en_pipe: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_flop_en_pipe;
    localparam logic [7:0] RV = 8'h3C;
    logic       clk = 1'b0;
    logic       rst, en, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] d, q;
`ifdef FLOP_PIPE_OCC_EN
    logic [1:0] occ;
`endif
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    flop_en_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .q(q)
`ifdef FLOP_PIPE_OCC_EN
        , .occ(occ)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_occ(input int e);
`ifdef FLOP_PIPE_OCC_EN
        chk("occ", 32'(occ), 32'(e));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every delivered word must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_extra got=%0h exp=none", q);
            end else begin
                chk("mon_q", 32'(q), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
        tick();
        chk("rst_in_ready_en0", 32'(in_ready), 0);
        tick();
        rst = 1'b0; en = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_q", 32'(q), 32'(RV));
        chk("rst_in_ready", 32'(in_ready), 1);
        chk_occ(0);

        // streaming: 3-cycle latency, then one word per cycle
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) exp_q.push_back(8'(k));
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 5);
            d = 8'(c + 1);
            #1;
            chk("t2_in_ready", 32'(in_ready), 1);
            chk("t2_out_valid", 32'(out_valid), 32'(c >= 3 && c <= 7));
            if (c >= 3 && c <= 7) chk("t2_q", 32'(q), 32'(c - 2));
            tick();
        end

        // fill to capacity with a stalled sink, then pass-through while full
        out_ready = 1'b0;
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'h55);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            d = 8'hA0 + 8'(c);
            #1;
            chk("t3_fill_in_ready", 32'(in_ready), 1);
            tick();
        end
        d = 8'hA3;
        #1;
        chk("t3_full_in_ready", 32'(in_ready), 0);
        chk("t3_full_out_valid", 32'(out_valid), 1);
        chk("t3_full_q", 32'(q), 32'hA0);
        chk_occ(3);
        tick();
        out_ready = 1'b1; d = 8'h55;
        #1;
        chk("t4_in_ready", 32'(in_ready), 1);
        chk("t4_q", 32'(q), 32'hA0);
        tick();
        in_valid = 1'b0;
        #1;
        chk_occ(3);
        tick();
        repeat (2) tick();
        chk("t4_drained", 32'(out_valid), 0);
        chk_occ(0);

        // bubble collapse: second word lands right behind the first
        out_ready = 1'b0; in_valid = 1'b1; d = 8'h10;
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        in_valid = 1'b1; d = 8'h11;
        #1;
        chk("t5_in_ready", 32'(in_ready), 1);
        chk("t5_q_head", 32'(q), 32'h10);
        tick();
        in_valid = 1'b0;
        #1;
        chk_occ(2);
        tick();
        chk("t5_out_valid", 32'(out_valid), 1);
        chk("t5_q", 32'(q), 32'h10);
        chk("t5_in_ready_after", 32'(in_ready), 1);
        chk_occ(2);

        // freeze with en=0
        en = 1'b0; in_valid = 1'b1; d = 8'h77; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t6_frz_in_ready", 32'(in_ready), 0);
            chk("t6_frz_out_valid", 32'(out_valid), 0);
            chk("t6_frz_q", 32'(q), 32'h10);
            tick();
        end
        en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("t6_thaw_out_valid", 32'(out_valid), 1);
        chk("t6_thaw_q", 32'(q), 32'h10);
        chk_occ(2);
        tick();

        // flush with a concurrent out_fire and a dropped input word
        flush = 1'b1; in_valid = 1'b1; d = 8'h99; out_ready = 1'b1;
        #1;
        chk("t6_flush_in_ready", 32'(in_ready), 1);
        chk("t6_flush_out_valid", 32'(out_valid), 1);
        tick();
        chk("t6_sb_left", 32'(exp_q.size()), 1);
        exp_q.delete();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("t6_post_out_valid", 32'(out_valid), 0);
        chk("t6_post_q", 32'(q), 32'h10);
        chk_occ(0);
        tick();
        chk("t6_dropped", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
